// File: rtl/sprite_rom_arbiter_pkg.sv
// Shared definitions for the sprite ROM arbiter: FSM state encoding and the
// default ROM geometry that the renderers and bitmap ROMs also use.
package sprite_rom_arbiter_pkg;

  localparam int DEF_ADDR_W = 4;
  localparam int DEF_DATA_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_ACK   = 2'd2
  } arb_state_e;

endpackage

// File: rtl/sprite_rr_picker.sv
// Round-robin winner search: the first asserted request at or after ptr,
// wrapping modulo NREQ. Purely combinational.
module sprite_rr_picker #(
  parameter int NREQ = 4
) (
  input  logic [NREQ-1:0]         req,
  input  logic [$clog2(NREQ)-1:0] ptr,
  output logic [$clog2(NREQ)-1:0] winner,
  output logic                    found
);

  localparam int PW = $clog2(NREQ);

  int idx;

  // Scan from the farthest offset back to ptr so the nearest request wins.
  always_comb begin
    winner = '0;
    found  = 1'b0;
    idx    = 0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      idx = (int'(ptr) + k) % NREQ;
      if (req[idx]) begin
        winner = idx[PW-1:0];
        found  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/sprite_rom_arbiter.sv
// Shares one combinational sprite bitmap ROM among NREQ renderers using a
// three-cycle IDLE/FETCH/ACK transaction with round-robin grants.
module sprite_rom_arbiter
  import sprite_rom_arbiter_pkg::*;
#(
  parameter int NREQ   = 4,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   en,
  input  logic [NREQ-1:0]        req,
  input  logic [NREQ*ADDR_W-1:0] req_addr,
  output logic [NREQ-1:0]        ack,
  output logic [DATA_W-1:0]      rd_data,
  output logic [ADDR_W-1:0]      rom_addr,
  input  logic [DATA_W-1:0]      rom_bits,
  output logic                   busy
);

  localparam int PW = $clog2(NREQ);

  arb_state_e          state_q, state_d;
  logic [PW-1:0]       ptr_q, ptr_d;
  logic [PW-1:0]       sel_q, sel_d;
  logic [ADDR_W-1:0]   rom_addr_q, rom_addr_d;
  logic [DATA_W-1:0]   rd_data_q, rd_data_d;
  logic [NREQ-1:0]     ack_q, ack_d;

  logic [PW-1:0]       winner;
  logic                found;

  sprite_rr_picker #(
    .NREQ(NREQ)
  ) u_picker (
    .req    (req),
    .ptr    (ptr_q),
    .winner (winner),
    .found  (found)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      ptr_q      <= '0;
      sel_q      <= '0;
      rom_addr_q <= '0;
      rd_data_q  <= '0;
      ack_q      <= '0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      sel_q      <= sel_d;
      rom_addr_q <= rom_addr_d;
      rd_data_q  <= rd_data_d;
      ack_q      <= ack_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    sel_d      = sel_q;
    rom_addr_d = rom_addr_q;
    rd_data_d  = rd_data_q;
    ack_d      = '0;
    case (state_q)
      ST_IDLE: begin
        // Inputs are only looked at here; later changes cannot disturb a fetch.
        if (en && found) begin
          rom_addr_d = req_addr[int'(winner)*ADDR_W +: ADDR_W];
          sel_d      = winner;
          ptr_d      = (int'(winner) == NREQ - 1) ? '0 : winner + 1'b1;
          state_d    = ST_FETCH;
        end
      end
      ST_FETCH: begin
        rd_data_d       = rom_bits;
        ack_d[sel_q]    = 1'b1;
        state_d         = ST_ACK;
      end
      ST_ACK: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign ack      = ack_q;
  assign rd_data  = rd_data_q;
  assign rom_addr = rom_addr_q;
  assign busy     = (state_q != ST_IDLE);

endmodule

// File: tb/tb_sprite_rom_arbiter.sv
// Directed bench for sprite_rom_arbiter: a scoreboard queue holds the expected
// {ack, rd_data} of every transaction and is drained as ack pulses appear.
module tb_sprite_rom_arbiter;

  localparam int NREQ   = 4;
  localparam int ADDR_W = 4;
  localparam int DATA_W = 8;

  logic                   clk = 1'b0;
  logic                   reset;
  logic                   en;
  logic [NREQ-1:0]        req;
  logic [NREQ*ADDR_W-1:0] req_addr;
  logic [NREQ-1:0]        ack;
  logic [DATA_W-1:0]      rd_data;
  logic [ADDR_W-1:0]      rom_addr;
  logic [DATA_W-1:0]      rom_bits;
  logic                   busy;

  int tests = 0;
  int fails = 0;
  logic [11:0] sb_q[$];

  always #5 clk = ~clk;

  // ROM model: row data is 0xA in the high nibble, the address in the low one.
  assign rom_bits = {4'hA, rom_addr};

  sprite_rom_arbiter #(
    .NREQ  (NREQ),
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .en      (en),
    .req     (req),
    .req_addr(req_addr),
    .ack     (ack),
    .rd_data (rd_data),
    .rom_addr(rom_addr),
    .rom_bits(rom_bits),
    .busy    (busy)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock, sampled 1ns after the edge; any ack pulse is matched against the scoreboard.
  task automatic tick();
    logic [11:0] e;
    @(posedge clk);
    #1;
    if (ack !== '0) begin
      if (sb_q.size() == 0) begin
        check("unexpected_ack", {28'd0, ack}, 32'd0);
      end else begin
        e = sb_q.pop_front();
        check("sb_ack", {28'd0, ack}, {28'd0, e[11:8]});
        check("sb_data", {24'd0, rd_data}, {24'd0, e[7:0]});
        $display("[TB] ack=%b rd_data=%h (expected ack=%b data=%h)", ack, rd_data, e[11:8], e[7:0]);
      end
    end
  endtask

  function automatic logic [11:0] exp_of(input int r, input logic [3:0] addr);
    logic [3:0] oh;
    oh = 4'b0001 << r;
    return {oh, 4'hA, addr};
  endfunction

  initial begin
    reset    = 1'b1;
    en       = 1'b0;
    req      = '0;
    req_addr = {4'h4, 4'h7, 4'h2, 4'h1};
    @(posedge clk);
    @(posedge clk);
    #1;
    check("reset_ack", {28'd0, ack}, 32'd0);
    check("reset_rd_data", {24'd0, rd_data}, 32'd0);
    check("reset_rom_addr", {28'd0, rom_addr}, 32'd0);
    check("reset_busy", {31'd0, busy}, 32'd0);
    reset = 1'b0;

    // Single request from requester 2, slice 2 = 7.
    en  = 1'b1;
    req = 4'b0100;
    sb_q.push_back(exp_of(2, 4'h7));
    tick();
    check("lat_rom_addr_n1", {28'd0, rom_addr}, 32'h7);
    check("lat_busy_n1", {31'd0, busy}, 32'd1);
    check("lat_ack_n1", {28'd0, ack}, 32'd0);
    tick();
    check("lat_ack_n2", {28'd0, ack}, 32'b0100);
    check("lat_data_n2", {24'd0, rd_data}, 32'hA7);
    check("lat_busy_n2", {31'd0, busy}, 32'd1);
    req = 4'b0000;
    tick();
    check("lat_ack_n3", {28'd0, ack}, 32'd0);
    check("lat_busy_n3", {31'd0, busy}, 32'd0);
    check("rd_data_hold", {24'd0, rd_data}, 32'hA7);

    // Reset in the middle of FETCH aborts without an ack.
    req = 4'b0001;
    tick();
    check("pre_abort_busy", {31'd0, busy}, 32'd1);
    reset = 1'b1;
    #1;
    check("abort_ack", {28'd0, ack}, 32'd0);
    check("abort_rd_data", {24'd0, rd_data}, 32'd0);
    check("abort_rom_addr", {28'd0, rom_addr}, 32'd0);
    check("abort_busy", {31'd0, busy}, 32'd0);
    #1;
    reset = 1'b0;

    // All requesting from reset: grants 0,1,2,3,0, one every 3 cycles.
    req = 4'b1111;
    for (int g = 0; g < 5; g++) begin
      logic [3:0] a;
      logic [11:0] e;
      a = req_addr[(g % 4)*ADDR_W +: ADDR_W];
      e = exp_of(g % 4, a);
      sb_q.push_back(e);
      tick();
      check("rr_fetch_no_ack", {28'd0, ack}, 32'd0);
      tick();
      check("rr_grant", {28'd0, ack}, {28'd0, e[11:8]});
      if (g == 4) req = 4'b0000;
      tick();
    end

    // Serve requester 3 so the pointer wraps back to 0.
    req = 4'b1000;
    sb_q.push_back(exp_of(3, 4'h4));
    tick();
    tick();
    check("wrap_grant3", {28'd0, ack}, 32'b1000);
    req = 4'b0000;
    tick();

    // Window closed: nothing is granted.
    en  = 1'b0;
    req = 4'b0011;
    for (int c = 0; c < 20; c++) tick();
    check("en_low_busy", {31'd0, busy}, 32'd0);
    check("en_low_queue", sb_q.size(), 32'd0);

    // Open the window, drop it again during FETCH; the transaction still completes.
    en = 1'b1;
    sb_q.push_back(exp_of(0, 4'h1));
    tick();
    en = 1'b0;
    tick();
    check("en_drop_ack", {28'd0, ack}, 32'b0001);
    tick();
    for (int c = 0; c < 4; c++) tick();
    check("en_drop_idle", {31'd0, busy}, 32'd0);

    // Requester 1 just served gets lowest priority next.
    en  = 1'b1;
    req = 4'b0010;
    sb_q.push_back(exp_of(1, 4'h2));
    tick();
    tick();
    check("prio_first", {28'd0, ack}, 32'b0010);
    req = 4'b0011;
    tick();
    sb_q.push_back(exp_of(0, 4'h1));
    tick();
    tick();
    check("prio_second", {28'd0, ack}, 32'b0001);
    req = 4'b0000;
    tick();

    // Address change during FETCH does not affect the latched address.
    req = 4'b0100;
    sb_q.push_back(exp_of(2, 4'h7));
    tick();
    req_addr[2*ADDR_W +: ADDR_W] = 4'hF;
    tick();
    check("addr_latch_data", {24'd0, rd_data}, 32'hA7);
    req = 4'b0000;
    tick();

    // Any expectation left over means an ack never arrived.
    for (int c = 0; c < 10 && sb_q.size() != 0; c++) tick();
    check("sb_drained", sb_q.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/sprite_rom_arbiter.md
Name: sprite_rom_arbiter

Overview:
- Shares one combinational 8-bit sprite bitmap ROM among NREQ sprite renderers, fetching one ROM row per transaction.
- Sits between the renderers' row-load logic and the single car/sprite bitmap ROM.
- Fetch uses the two-step setup/fetch sequence (drive address, then latch data), arbitrated round-robin.
- New grants start only inside an enable window (normally hsync) so all rows are ready before drawing.

Parameters:
- NREQ, 4, number of requesting renderers (2..8).
- ADDR_W, 4, ROM row address width.
- DATA_W, 8, ROM row width.

Ports:
- clk  input  1  system clock.
- reset  input  1  asynchronous, active-high reset.
- en  input  1  grant window; new transactions start only while high.
- req  input  NREQ  per-requester fetch request (level).
- req_addr  input  NREQ*ADDR_W  packed row addresses; requester i uses slice [i*ADDR_W +: ADDR_W].
- ack  output  NREQ  one-hot, one-cycle pulse: rd_data valid for that requester.
- rd_data  output  DATA_W  latched ROM row, shared by all requesters.
- rom_addr  output  ADDR_W  registered ROM address.
- rom_bits  input  DATA_W  ROM data, combinational from rom_addr.
- busy  output  1  high in any state other than IDLE.

Behaviour:
- Reset (async, immediate) sets:
  - state=IDLE, ack=0, rd_data=0, rom_addr=0, busy=0, ptr=0.
  - The internal winner index sel=0.
- State machine, 3 cycles per transaction, no pipelining:
  - IDLE:
    - If en && |req: pick winner w by round-robin starting at ptr, searching ptr, ptr+1, … mod NREQ.
    - Register rom_addr<=req_addr slice w, sel<=w, ptr<=(w+1) mod NREQ, then go to FETCH.
    - Else stay in IDLE.
  - FETCH:
    - rom_addr is stable.
    - Register rd_data<=rom_bits and ack<=onehot(sel), then go to ACK.
  - ACK:
    - ack is high for exactly this one cycle and rd_data is valid.
    - Clear ack at the end of the cycle and return to IDLE.
    - No arbitration happens in this cycle.
  - Unknown state encoding: return to IDLE with ack=0.
- Latency:
  - A request seen in IDLE at cycle N produces ack at cycle N+2.
  - The next grant decision can be made at N+3.
- rd_data holds its value until the next FETCH; it is never cleared except by reset.
- req, req_addr and en are sampled only in IDLE; changes in FETCH/ACK have no effect on the in-flight transaction.
- Requester protocol:
  - Hold req until its ack.
  - Keeping req high after ack requests another row; the requester updates req_addr in the ack cycle.
  - A requester that was just served has lowest priority at the next decision.
- en low during FETCH/ACK: the transaction completes normally. en low in IDLE: no grant, ptr unchanged.
- All req low: stay in IDLE, outputs held, ptr unchanged.
- Single requester continuously asserting: served every 3 cycles.
- Reset mid-transaction aborts: no ack pulse, rd_data=0.

Decomposition:
- Shared include header (sprite_defs.v, guarded) holds:
  - State localparams: IDLE=0, FETCH=1, ACK=2.
  - Default ADDR_W/DATA_W constants, shared with sprite_renderer and the bitmap ROMs.
- Sub-module sprite_rr_picker (combinational):
  - Inputs req[NREQ], ptr.
  - Outputs winner index and found flag.
  - Keeps the priority rotation separately testable.

Test Plan:
- Reset: assert reset mid-FETCH → next clk edge not needed.
  - ack=0, rd_data=0, rom_addr=0 and busy=0 immediately.
  - After release, ptr=0.
- ROM model rom_bits={4'hA,rom_addr}, NREQ=4, en=1, req=4'b0100, slice2=4'h7:
  - cycle N IDLE; rom_addr=7 from N+1.
  - ack=4'b0100 and rd_data=8'hA7 at N+2 only; busy high N+1..N+2.
- All req=4'b1111 held, en=1 from reset → grant order 0,1,2,3,0, each ack 3 cycles apart.
- en=0 with req=4'b0011 → no ack for 20 cycles.
  - Raising en → requester 0 acked 2 cycles after the first IDLE cycle with en high.
  - Dropping en in FETCH still yields that ack.
- Requester 1 served, then req=4'b0011 → next ack goes to requester 0, not 1.
- req_addr slice changed to 4'hF during FETCH → rd_data still from the address latched in IDLE.
